apb_master_ctrl: RTL and testbench

- APB master that sequences single read/write transfers from a simple request/response port onto the shared APB bus for two 8-bit slaves (slave 1 and slave 2).
- Runs the IDLE -> SETUP -> ACCESS protocol and decodes request address bit 8 into PSEL1/PSEL2.
- Muxes PRDATA/PREADY back from the selected slave.
- Aborts with an error response if the selected slave stalls beyond a wait-state limit.

---
 rtl/apb_pkg.sv | 14 +
 rtl/apb_master_ctrl_if.sv | 40 ++++
 rtl/apb_wait_timer.sv | 27 ++
 rtl/apb_master_ctrl.sv | 108 ++++++++++
 tb/tb_apb_master_ctrl.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and constants for the APB master controller
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam int APB_ADDR_W  = 8;
    localparam int APB_DATA_W  = 8;
    localparam int SLV_SEL_BIT = 8;

endpackage

// File: rtl/apb_master_ctrl_if.sv
// rtl/apb_master_ctrl_if.sv - request/response port and two-slave APB bus bundle
interface apb_master_ctrl_if
    import apb_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W:0]   req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              PSEL1;
    logic              PSEL2;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA1;
    logic [DATA_W-1:0] PRDATA2;
    logic              PREADY1;
    logic              PREADY2;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        input  PRDATA1, PRDATA2, PREADY1, PREADY2,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        output PRDATA1, PRDATA2, PREADY1, PREADY2,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_wait_timer.sv
// rtl/apb_wait_timer.sv - ACCESS wait-state counter with expiry at TIMEOUT_CYCLES
module apb_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam logic [7:0] LIMIT_M1 = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 8'd0;
        end else if (i_clear) begin
            r_count <= 8'd0;
        end else if (i_enable) begin
            r_count <= r_count + 8'd1;
        end
    end

    // Flags the wait cycle whose increment reaches the limit, so the abort lands on that edge.
    assign o_expired = i_enable && (r_count == LIMIT_M1);
endmodule

// File: rtl/apb_master_ctrl.sv
// rtl/apb_master_ctrl.sv - APB master sequencing single transfers to two slaves
module apb_master_ctrl
    import apb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = APB_ADDR_W,
    parameter int DATA_W         = APB_DATA_W
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    apb_master_ctrl_if.master bus
);
    state_t            r_state;
    logic              r_sel2;
    logic              r_req_ready;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;
    logic              r_psel1;
    logic              r_psel2;
    logic              r_penable;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;

    logic              w_sel_ready;
    logic [DATA_W-1:0] w_sel_rdata;
    logic              w_accept;
    logic              w_wait;
    logic              w_expired;

    // Only the addressed slave is listened to; the other slave's ready/data are ignored.
    assign w_sel_ready = r_sel2 ? bus.PREADY2 : bus.PREADY1;
    assign w_sel_rdata = r_sel2 ? bus.PRDATA2 : bus.PRDATA1;
    assign w_accept    = (r_state == IDLE) && bus.req_valid;
    assign w_wait      = (r_state == ACCESS) && !w_sel_ready;

    apb_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk      (PCLK),
        .rst_n    (PRESETn),
        .i_clear  (w_accept),
        .i_enable (w_wait),
        .o_expired(w_expired)
    );

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state     <= IDLE;
            r_sel2      <= 1'b0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_psel1     <= 1'b0;
            r_psel2     <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_pwrite    <= bus.req_write;
                        r_paddr     <= bus.req_addr[ADDR_W-1:0];
                        r_pwdata    <= bus.req_wdata;
                        r_sel2      <= bus.req_addr[SLV_SEL_BIT];
                        r_psel1     <= !bus.req_addr[SLV_SEL_BIT];
                        r_psel2     <= bus.req_addr[SLV_SEL_BIT];
                        r_req_ready <= 1'b0;
                        r_state     <= SETUP;
                    end
                end
                SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ACCESS;
                end
                ACCESS: begin
                    if (w_sel_ready || w_expired) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= !w_sel_ready;
                        r_rsp_rdata <= (w_sel_ready && !r_pwrite) ? w_sel_rdata : '0;
                        r_psel1     <= 1'b0;
                        r_psel2     <= 1'b0;
                        r_penable   <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.PSEL1     = r_psel1;
    assign bus.PSEL2     = r_psel2;
    assign bus.PENABLE   = r_penable;
    assign bus.PWRITE    = r_pwrite;
    assign bus.PADDR     = r_paddr;
    assign bus.PWDATA    = r_pwdata;
endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb/tb_apb_master_ctrl.sv - randomized bench with transaction-level reference model
module tb_apb_master_ctrl;
    localparam int TO = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    apb_master_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    apb_master_ctrl #(
        .TIMEOUT_CYCLES(TO),
        .ADDR_W        (8),
        .DATA_W        (8)
    ) dut (
        .PCLK   (clk),
        .PRESETn(rst_n),
        .bus    (bus.master)
    );

    int tests = 0;
    int fails = 0;

    logic       use_mem = 1'b0;
    logic [7:0] rnd_rd1 = 8'h00;
    logic [7:0] rnd_rd2 = 8'h00;
    logic [7:0] mem1 [256];
    logic [7:0] mem2 [256];

    // Reference model: one in-flight transfer with its age since acceptance.
    bit         m_busy  = 1'b0;
    int         m_age   = 0;
    int         m_waits = 0;
    bit         m_write = 1'b0;
    logic [8:0] m_addr  = 9'h0;
    logic [7:0] m_wdata = 8'h0;
    bit         e_rsp_valid = 1'b0;
    bit         e_rsp_err   = 1'b0;
    logic [7:0] e_rsp_rdata = 8'h0;

    assign bus.PRDATA1 = use_mem ? mem1[m_addr[7:0]] : rnd_rd1;
    assign bus.PRDATA2 = use_mem ? mem2[m_addr[7:0]] : rnd_rd2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin : model
        bit         rdy;
        logic [7:0] rd;
        if (!rst_n) begin
            m_busy      = 1'b0;
            m_age       = 0;
            m_waits     = 0;
            e_rsp_valid = 1'b0;
            e_rsp_err   = 1'b0;
            e_rsp_rdata = 8'h0;
        end else begin
            e_rsp_valid = 1'b0;
            if (!m_busy) begin
                if (bus.req_valid) begin
                    m_busy  = 1'b1;
                    m_age   = 1;
                    m_waits = 0;
                    m_write = bus.req_write;
                    m_addr  = bus.req_addr;
                    m_wdata = bus.req_wdata;
                end
            end else if (m_age == 1) begin
                m_age = 2;
            end else begin
                rdy = m_addr[8] ? bus.PREADY2 : bus.PREADY1;
                rd  = m_addr[8] ? bus.PRDATA2 : bus.PRDATA1;
                if (rdy) begin
                    e_rsp_valid = 1'b1;
                    e_rsp_err   = 1'b0;
                    e_rsp_rdata = m_write ? 8'h00 : rd;
                    if (m_write && m_addr[8])  mem2[m_addr[7:0]] = m_wdata;
                    if (m_write && !m_addr[8]) mem1[m_addr[7:0]] = m_wdata;
                    m_busy = 1'b0;
                end else begin
                    m_waits++;
                    if (m_waits == TO) begin
                        e_rsp_valid = 1'b1;
                        e_rsp_err   = 1'b1;
                        e_rsp_rdata = 8'h00;
                        m_busy      = 1'b0;
                    end
                end
            end
        end
    end

    bit checking = 1'b0;

    always @(negedge clk) begin
        if (checking) begin
            check("req_ready", bus.req_ready, !m_busy);
            check("psel1", bus.PSEL1, m_busy && !m_addr[8]);
            check("psel2", bus.PSEL2, m_busy && m_addr[8]);
            check("penable", bus.PENABLE, m_busy && (m_age == 2));
            check("rsp_valid", bus.rsp_valid, e_rsp_valid);
            check("psel_excl", bus.PSEL1 & bus.PSEL2, 1'b0);
            if (m_busy) begin
                check("paddr", bus.PADDR, m_addr[7:0]);
                check("pwrite", bus.PWRITE, m_write);
                check("pwdata", bus.PWDATA, m_wdata);
            end
            if (e_rsp_valid) begin
                check("rsp_rdata", bus.rsp_rdata, e_rsp_rdata);
                check("rsp_err", bus.rsp_err, e_rsp_err);
            end
        end
    end

    task automatic set_ready(input bit sel2, input bit v);
        if (sel2) begin
            bus.PREADY2 = v;
            bus.PREADY1 = 1'b1;
        end else begin
            bus.PREADY1 = v;
            bus.PREADY2 = 1'b1;
        end
    endtask

    // Issue a request in the current cycle; selected ready stays low for `waits` ACCESS edges.
    task automatic xfer(input bit wr, input logic [8:0] addr, input logic [7:0] wd, input int waits,
                        output int cyc, output logic [7:0] rd, output bit err);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        set_ready(addr[8], waits == 0);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            bus.req_valid = 1'b0;
            set_ready(addr[8], cyc >= waits + 2);
        end while (!bus.rsp_valid && cyc < 40);
        rd  = bus.rsp_rdata;
        err = bus.rsp_err;
        if (!bus.rsp_valid) check("xfer_bound", 32'd0, 32'd1);
    endtask

    initial begin : stim
        int         cyc;
        logic [7:0] rd;
        bit         err;
        for (int i = 0; i < 256; i++) begin
            mem1[i] = 8'h00;
            mem2[i] = 8'h00;
        end
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 9'h0;
        bus.req_wdata = 8'h0;
        bus.PREADY1   = 1'b0;
        bus.PREADY2   = 1'b0;

        repeat (2) @(negedge clk);
        checking = 1'b1;
        check("reset_req_ready", bus.req_ready, 1'b1);
        check("reset_psel1", bus.PSEL1, 1'b0);
        check("reset_rsp_valid", bus.rsp_valid, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        xfer(1'b1, 9'h012, 8'hA5, 0, cyc, rd, err);
        check("wr0_cycles", cyc, 3);
        check("wr0_err", err, 1'b0);

        rnd_rd2 = 8'h5C;
        xfer(1'b0, 9'h134, 8'h00, 2, cyc, rd, err);
        check("rd2_cycles", cyc, 5);
        check("rd2_rdata", rd, 8'h5C);
        check("rd2_model_rdata", e_rsp_rdata, 8'h5C);

        xfer(1'b0, 9'h020, 8'h00, 255, cyc, rd, err);
        check("to_cycles", cyc, 6);
        check("to_err", err, 1'b1);
        check("to_rdata", rd, 8'h00);
        check("to_model_err", e_rsp_err, 1'b1);
        xfer(1'b1, 9'h021, 8'h3C, 0, cyc, rd, err);
        check("after_to_cycles", cyc, 3);
        check("after_to_err", err, 1'b0);

        use_mem = 1'b1;
        xfer(1'b1, 9'h010, 8'h11, 0, cyc, rd, err);
        xfer(1'b0, 9'h010, 8'h00, 0, cyc, rd, err);
        check("b2b_cycles", cyc, 3);
        check("b2b_rdata", rd, 8'h11);
        use_mem = 1'b0;

        rnd_rd1 = 8'h77;
        xfer(1'b0, 9'h055, 8'h00, 2, cyc, rd, err);
        check("xslave_cycles", cyc, 5);
        check("xslave_rdata", rd, 8'h77);

        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 9'h040;
        bus.req_wdata = 8'h99;
        bus.PREADY1   = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_psel1", bus.PSEL1, 1'b0);
        check("rst_penable", bus.PENABLE, 1'b0);
        check("rst_req_ready", bus.req_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_no_rsp", bus.rsp_valid, 1'b0);
            check("rst_ready_after", bus.req_ready, 1'b1);
        end

        for (int i = 0; i < 3000; i++) begin
            bus.req_valid = ($urandom_range(0, 1) == 1);
            bus.req_write = ($urandom_range(0, 1) == 1);
            bus.req_addr  = 9'($urandom_range(0, 511));
            bus.req_wdata = 8'($urandom_range(0, 255));
            bus.PREADY1   = ($urandom_range(0, 9) < 6);
            bus.PREADY2   = ($urandom_range(0, 9) < 6);
            rnd_rd1       = 8'($urandom_range(0, 255));
            rnd_rd2       = 8'($urandom_range(0, 255));
            @(negedge clk);
        end

        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
